carro_scheduler: RTL

- Sequencer for the pool of falling obstacle cars (car position registers) in the VGA game.
- Issues per-car load (enable), step-down (resta) and respawn (salto) pulses; paces motion from the frame tick; spawns cars into pseudo-random lanes; counts cars that leave the screen as score.
- Sits between the game top-level FSM / VGA timing and the NUM_CARS car position instances.

---
 rtl/carro_scheduler_pkg.sv | 30 +++
 rtl/carro_scheduler_lfsr8.sv | 39 +++
 rtl/carro_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/carro_scheduler_pkg.sv
// Shared definitions for the obstacle-car scheduler: state encoding, lane
// geometry, park coordinates and score sizing.
package carro_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } estado_t;

    localparam int         SCORE_W   = 8;
    localparam logic [7:0] SCORE_MAX = 8'd255;
    localparam logic [8:0] SCREEN_H  = 9'd480;
    localparam logic [9:0] PARK_X    = 10'd0;
    localparam logic [8:0] PARK_Y    = 9'd0;
    localparam logic [8:0] SPAWN_Y   = 9'd0;

    function automatic logic [9:0] lane_x(input logic [1:0] lane);
        logic [9:0] x;
        case (lane)
            2'd0:    x = 10'd160;
            2'd1:    x = 10'd240;
            2'd2:    x = 10'd320;
            2'd3:    x = 10'd400;
            default: x = 10'd160;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/carro_scheduler_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick spawn lanes.
module carro_scheduler_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iEn,
    output logic [7:0] oLfsr
);

    logic [7:0] r_lfsr;
    logic [7:0] w_next;
    logic       w_fb;

    assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign oLfsr = r_lfsr;

    // Next state; an all-zero lockup (e.g. from an upset) reloads the seed
    always_comb begin
        w_next = {r_lfsr[6:0], w_fb};
        if (r_lfsr == 8'd0) begin
            w_next = SEED;
        end else begin
            w_next = {r_lfsr[6:0], w_fb};
        end
    end

    // Shift register
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_lfsr <= SEED;
        end else if (iEn) begin
            r_lfsr <= w_next;
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

endmodule

// File: rtl/carro_scheduler.sv
// Sequencer for the falling-car pool: paces steps from the frame tick, spawns
// cars into random lanes, parks them on stop and keeps a saturating score.
module carro_scheduler
    import carro_scheduler_pkg::*;
#(
    parameter int         NUM_CARS  = 4,
    parameter int         TICK_DIV  = 4,
    parameter int         SPAWN_GAP = 60,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                iClk,
    input  logic                iReset_n,
    input  logic                iFrameTick,
    input  logic                iRun,
    input  logic                iColision,
    input  logic [NUM_CARS-1:0] iCarroFin,
    output logic [NUM_CARS-1:0] oEnable,
    output logic [NUM_CARS-1:0] oResta,
    output logic [NUM_CARS-1:0] oSalto,
    output logic [9:0]          oPosicionX,
    output logic [8:0]          oPosicionY,
    output logic [NUM_CARS-1:0] oActivos,
    output logic [7:0]          oPuntos,
    output logic [1:0]          oEstado
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SP_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam int CNT_W = $clog2(NUM_CARS + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [SP_W-1:0]  SP_MAX  = SP_W'(SPAWN_GAP - 1);

    estado_t               r_estado, w_estado_next;
    logic [NUM_CARS-1:0]   r_enable, r_resta, r_salto, r_activos;
    logic [NUM_CARS-1:0]   w_enable_next, w_resta_next, w_salto_next, w_activos_next;
    logic [9:0]            r_pos_x, w_pos_x_next;
    logic [8:0]            r_pos_y, w_pos_y_next;
    logic [SCORE_W-1:0]    r_puntos, w_puntos_next, w_puntos_sat;
    logic [DIV_W-1:0]      r_div, w_div_next;
    logic [SP_W-1:0]       r_spawn, w_spawn_next;
    logic [7:0]            w_lfsr;
    logic [1:0]            w_lane;
    logic [NUM_CARS-1:0]   w_fin_valid, w_free, w_slot;
    logic [CNT_W-1:0]      w_fin_cnt;
    logic [SCORE_W:0]      w_sum;

    carro_scheduler_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iEn      (1'b1),
        .oLfsr    (w_lfsr)
    );

    // A slot being loaded this cycle is not yet in the mask, so it is excluded too
    assign w_free      = ~(r_activos | r_enable);
    assign w_slot      = w_free & (~w_free + NUM_CARS'(1));
    assign w_lane      = (w_lfsr != 8'd0) ? w_lfsr[1:0] : 2'd0;
    assign w_fin_valid = iCarroFin & r_activos;

    // Count finished active cars and add them to the score with saturation
    always_comb begin
        w_fin_cnt = '0;
        for (int k = 0; k < NUM_CARS; k++) begin
            w_fin_cnt = w_fin_cnt + CNT_W'(w_fin_valid[k]);
        end
        w_sum        = {1'b0, r_puntos} + (SCORE_W + 1)'(w_fin_cnt);
        w_puntos_sat = (w_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_sum[SCORE_W-1:0];
    end

    // Next-state and output decode
    always_comb begin
        w_estado_next  = r_estado;
        w_enable_next  = '0;
        w_resta_next   = '0;
        w_salto_next   = '0;
        w_pos_x_next   = r_pos_x;
        w_pos_y_next   = r_pos_y;
        w_activos_next = r_activos;
        w_puntos_next  = r_puntos;
        w_div_next     = r_div;
        w_spawn_next   = r_spawn;
        case (r_estado)
            ST_IDLE: begin
                if (iRun) begin
                    w_estado_next  = ST_RUN;
                    w_activos_next = '0;
                    w_puntos_next  = '0;
                    w_div_next     = '0;
                    w_spawn_next   = SP_MAX;
                end else begin
                    w_estado_next  = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_activos_next = (r_activos & ~w_fin_valid) | r_enable;
                w_puntos_next  = w_puntos_sat;
                if (!iRun) begin
                    w_estado_next = ST_IDLE;
                    w_salto_next  = '1;
                    w_pos_x_next  = PARK_X;
                    w_pos_y_next  = PARK_Y;
                end else if (iColision) begin
                    w_estado_next = ST_STOP;
                end else if (iFrameTick && (r_div == DIV_MAX)) begin
                    w_div_next   = '0;
                    w_resta_next = r_activos;
                    if (r_spawn == SP_MAX) begin
                        if (|w_free) begin
                            w_enable_next = w_slot;
                            w_pos_x_next  = lane_x(w_lane);
                            w_pos_y_next  = SPAWN_Y;
                            w_spawn_next  = '0;
                        end else begin
                            w_spawn_next  = r_spawn;
                        end
                    end else begin
                        w_spawn_next = r_spawn + SP_W'(1);
                    end
                end else if (iFrameTick) begin
                    w_div_next = r_div + DIV_W'(1);
                end else begin
                    w_div_next = r_div;
                end
            end
            ST_STOP: begin
                if (!iRun) begin
                    w_estado_next = ST_IDLE;
                    w_salto_next  = '1;
                    w_pos_x_next  = PARK_X;
                    w_pos_y_next  = PARK_Y;
                end else begin
                    w_estado_next = ST_STOP;
                end
            end
            default: begin
                w_estado_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_estado  <= ST_IDLE;
            r_enable  <= '0;
            r_resta   <= '0;
            r_salto   <= '0;
            r_pos_x   <= '0;
            r_pos_y   <= '0;
            r_activos <= '0;
            r_puntos  <= '0;
            r_div     <= '0;
            r_spawn   <= '0;
        end else begin
            r_estado  <= w_estado_next;
            r_enable  <= w_enable_next;
            r_resta   <= w_resta_next;
            r_salto   <= w_salto_next;
            r_pos_x   <= w_pos_x_next;
            r_pos_y   <= w_pos_y_next;
            r_activos <= w_activos_next;
            r_puntos  <= w_puntos_next;
            r_div     <= w_div_next;
            r_spawn   <= w_spawn_next;
        end
    end

    assign oEnable    = r_enable;
    assign oResta     = r_resta;
    assign oSalto     = r_salto;
    assign oPosicionX = r_pos_x;
    assign oPosicionY = r_pos_y;
    assign oActivos   = r_activos;
    assign oPuntos    = r_puntos;
    assign oEstado    = r_estado;

endmodule
